// File: rtl/mac_arbiter_if.sv
// Requester, MAC-core and response signals of mac_arbiter.
// master: the arbiter itself. slave: requesters, MAC core and response consumer.
interface mac_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mac_a;
  logic [7:0]        mac_b;
  logic              mac_en;
  logic              mac_clr;
  logic [16:0]       mac_result;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [16:0]       resp_data;
  logic              resp_err;
  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, req_last, mac_result, resp_ready,
    output req_ready, mac_a, mac_b, mac_en, mac_clr,
           resp_valid, resp_id, resp_data, resp_err, busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_last, mac_result, resp_ready,
    input  req_ready, mac_a, mac_b, mac_en, mac_clr,
           resp_valid, resp_id, resp_data, resp_err, busy
  );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8x8 MAC among NREQ requesters.
// A granted requester owns the MAC for a whole burst; the tagged 17-bit sum
// is returned on the response channel.
// Optional feature: define MAC_ARB_TIMEOUT_EN to abort a burst after TIMEOUT
// consecutive RUN cycles without a beat (partial sum returned, resp_err=1).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | scan req_valid from ptr upward (wrapping), register grant
// CLR    | clear MAC accumulator, no beat accepted
// RUN    | stream beats of the granted requester into the MAC
// DRAIN  | capture MAC result, id and error flag; advance ptr
// RESP   | hold response until resp_ready
module mac_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           reset,
  mac_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_param_check
    $error("mac_arbiter: unsupported NREQ/IDW/TIMEOUT combination");
  end

  state_t         state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic           beat;
  logic [IDW-1:0] resp_id_q;
  logic [16:0]    resp_data_q;

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT - 1);
  logic [TW-1:0] idle_cnt;
  logic          timed_out;
  logic          resp_err_q;
`endif

  // Rotating-priority search: lowest offset from ptr with req_valid set wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        pick     = IDW'((int'(ptr) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign beat     = (state == S_RUN) && bus.req_valid[grant];

  // Ready depends on state/grant only; MAC operands follow the granted valid
  always_comb begin
    bus.req_ready = '0;
    bus.mac_en    = 1'b0;
    bus.mac_a     = '0;
    bus.mac_b     = '0;
    if (state == S_RUN) begin
      bus.req_ready[grant] = 1'b1;
      if (bus.req_valid[grant]) begin
        bus.mac_en = 1'b1;
        bus.mac_a  = bus.req_a[8*int'(grant) +: 8];
        bus.mac_b  = bus.req_b[8*int'(grant) +: 8];
      end
    end
  end

  // Sequencer: grant, clear, stream, capture, respond
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      grant       <= '0;
      ptr         <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timed_out   <= 1'b0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            state <= S_CLR;
          end
        end
        S_CLR: begin
          state <= S_RUN;
`ifdef MAC_ARB_TIMEOUT_EN
          idle_cnt  <= IDLE_LOAD;
          timed_out <= 1'b0;
`endif
        end
        S_RUN: begin
`ifdef MAC_ARB_TIMEOUT_EN
          if (beat) begin
            idle_cnt <= IDLE_LOAD;
            if (bus.req_last[grant]) state <= S_DRAIN;
          end else if (idle_cnt == '0) begin
            timed_out <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
`else
          if (beat && bus.req_last[grant]) state <= S_DRAIN;
`endif
        end
        S_DRAIN: begin
          resp_data_q <= bus.mac_result;
          resp_id_q   <= grant;
          ptr         <= ptr_next;
`ifdef MAC_ARB_TIMEOUT_EN
          resp_err_q  <= timed_out;
`endif
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mac_clr    = (state == S_CLR);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.busy       = (state != S_IDLE);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
`ifdef MAC_ARB_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: directed scenarios followed by randomized bursts
// checked against a round-robin / burst-sum reference model.
module tb_mac_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;
  localparam int NRESP   = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mac_rst_n;
  logic [16:0] mac_q;

  int checks   = 0;
  int failures = 0;

  mac_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mac_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Multiply-accumulate core model (not reset by the arbiter reset)
  always_ff @(posedge clk or negedge mac_rst_n) begin
    if (!mac_rst_n)       mac_q <= '0;
    else if (bus.mac_clr) mac_q <= '0;
    else if (bus.mac_en)  mac_q <= mac_q + 17'(bus.mac_a) * 17'(bus.mac_b);
  end
  assign bus.mac_result = mac_q;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_ready"},  32'(bus.req_ready), 0);
    chk({pfx, "_mac_a"},      32'(bus.mac_a), 0);
    chk({pfx, "_mac_b"},      32'(bus.mac_b), 0);
    chk({pfx, "_mac_en"},     32'(bus.mac_en), 0);
    chk({pfx, "_mac_clr"},    32'(bus.mac_clr), 0);
    chk({pfx, "_resp_valid"}, 32'(bus.resp_valid), 0);
    chk({pfx, "_resp_id"},    32'(bus.resp_id), 0);
    chk({pfx, "_resp_data"},  32'(bus.resp_data), 0);
    chk({pfx, "_resp_err"},   32'(bus.resp_err), 0);
    chk({pfx, "_busy"},       32'(bus.busy), 0);
  endtask

  // Round-robin rule: first requester with valid, scanning upward from p
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
    int k = 0;
    while (k < NREQ && !v[(p + k) % NREQ]) k++;
    return (k < NREQ) ? (p + k) % NREQ : -1;
  endfunction

  // Drives an n-beat burst of constant operands; starts and ends at a drive point
  task automatic run_burst(input int id, input int n, input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    bus.req_valid[id]      = 1'b1;
    bus.req_a[8*id +: 8]   = a;
    bus.req_b[8*id +: 8]   = b;
    bus.req_last[id]       = (n == 1);
    for (int c = 0; c < 60 && acc < n; c++) begin
      @(negedge clk);
      chk("others_ready", 32'(bus.req_ready & ~(NREQ'(1) << id)), 0);
      if (bus.req_ready[id]) acc++;
      cyc();
      if (acc == n) begin
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
      end else begin
        bus.req_last[id] = (acc == n - 1);
      end
    end
    chk("burst_accepted", acc, n);
  endtask

  // Waits for resp_valid within budget cycles; starts and ends at a drive point
  task automatic wait_resp(input int budget, output logic seen, output logic [IDW-1:0] id,
                           output logic [16:0] data, output logic err, output int lat);
    seen = 1'b0; id = '0; data = '0; err = 1'b0; lat = -1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1; id = bus.resp_id; data = bus.resp_data; err = bus.resp_err; lat = c;
      end
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
  endtask

  // Random-phase model state
  int              blen [NREQ];
  int              bidx [NREQ];
  int              bub  [NREQ];
  int              bsum [NREQ];
  int              done_sum [NREQ];
  bit              pend [NREQ];
  logic [7:0]      ba [NREQ][8];
  logic [7:0]      bb [NREQ][8];

  task automatic gen_burst(input int i);
    int s = 0;
    blen[i] = $urandom_range(1, 6);
    bidx[i] = 0;
    for (int j = 0; j < blen[i]; j++) begin
      ba[i][j] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      bb[i][j] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      s += int'(ba[i][j]) * int'(bb[i][j]);
    end
    bsum[i] = s % (1 << 17);
  endtask

  logic           r_seen;
  logic [IDW-1:0] r_id;
  logic [16:0]    r_data;
  logic           r_err;
  int             r_lat;
  int             n_resp;
  int             m_ptr;
  int             exp_id;
  bit             m_busy;
  bit             nxt_busy;
  bit             hold;
  logic [IDW-1:0] hold_id;
  logic [16:0]    hold_data;
  int             served;
  int             acc6;
  int             order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; mac_rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_last = '0;
    bus.resp_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk_zero("rst");
    cyc();
    rst_n = 1'b1; mac_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    // Single beat from requester 1: cycle-exact timing
    cyc();
    bus.req_valid[1] = 1'b1; bus.req_a[15:8] = 8'd3; bus.req_b[15:8] = 8'd5; bus.req_last[1] = 1'b1;
    @(negedge clk);
    chk("t1_c0_ready", 32'(bus.req_ready), 0);
    chk("t1_c0_clr", 32'(bus.mac_clr), 0);
    cyc();
    @(negedge clk);
    chk("t1_c1_clr", 32'(bus.mac_clr), 1);
    chk("t1_c1_ready", 32'(bus.req_ready), 0);
    chk("t1_c1_busy", 32'(bus.busy), 1);
    cyc();
    @(negedge clk);
    chk("t1_c2_ready", 32'(bus.req_ready), 32'b0010);
    chk("t1_c2_en", 32'(bus.mac_en), 1);
    chk("t1_c2_a", 32'(bus.mac_a), 3);
    chk("t1_c2_b", 32'(bus.mac_b), 5);
    cyc();
    bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0;
    @(negedge clk);
    chk("t1_c3_valid", 32'(bus.resp_valid), 0);
    chk("t1_c3_en", 32'(bus.mac_en), 0);
    cyc();
    @(negedge clk);
    chk("t1_c4_valid", 32'(bus.resp_valid), 1);
    chk("t1_c4_id", 32'(bus.resp_id), 1);
    chk("t1_c4_data", 32'(bus.resp_data), 15);
    chk("t1_c4_err", 32'(bus.resp_err), 0);
    cyc();
    @(negedge clk);
    chk("t1_c5_busy", 32'(bus.busy), 0);
    cyc();

    // Three beats of 255*255 from requester 0: wraps modulo 2^17
    run_burst(0, 3, 8'd255, 8'd255);
    wait_resp(20, r_seen, r_id, r_data, r_err, r_lat);
    chk("t2_seen", 32'(r_seen), 1);
    chk("t2_id", 32'(r_id), 0);
    chk("t2_data", 32'(r_data), (3 * 255 * 255) % (1 << 17));
    chk("t2_err", 32'(r_err), 0);

    // All four requesters pending after reset: round-robin order
    do_reset();
    bus.req_valid = '1; bus.req_last = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[8*i +: 8] = 8'(i + 1);
      bus.req_b[8*i +: 8] = 8'd10;
    end
    n_resp = 0;
    for (int c = 0; c < 80 && n_resp < 5; c++) begin
      @(negedge clk);
      if (n_resp < 5 && bus.req_ready != '0)
        chk("t3_ready_owner", 32'(bus.req_ready), 32'(1) << order[n_resp]);
      if (bus.resp_valid) begin
        chk("t3_id", 32'(bus.resp_id), order[n_resp]);
        chk("t3_data", 32'(bus.resp_data), (order[n_resp] + 1) * 10);
        n_resp++;
      end
      cyc();
      if (n_resp == 5) bus.req_valid = '0;
    end
    chk("t3_count", n_resp, 5);
    bus.req_last = '0;

    // Response back-pressure: 5 cycles with resp_ready low
    bus.resp_ready = 1'b0;
    bus.req_valid[3] = 1'b1; bus.req_a[31:24] = 8'd1; bus.req_b[31:24] = 8'd1; bus.req_last[3] = 1'b1;
    run_burst(2, 1, 8'd9, 8'd9);
    wait_resp(20, r_seen, r_id, r_data, r_err, r_lat);
    chk("t4_seen", 32'(r_seen), 1);
    chk("t4_id", 32'(r_id), 2);
    chk("t4_data", 32'(r_data), 81);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.resp_valid), 1);
      chk("t4_hold_id", 32'(bus.resp_id), 2);
      chk("t4_hold_data", 32'(bus.resp_data), 81);
      chk("t4_hold_clr", 32'(bus.mac_clr), 0);
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
      cyc();
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_valid", 32'(bus.resp_valid), 1);
    chk("t4_hs_clr", 32'(bus.mac_clr), 0);
    cyc();
    @(negedge clk);
    chk("t4_idle_busy", 32'(bus.busy), 0);
    chk("t4_idle_clr", 32'(bus.mac_clr), 0);
    cyc();
    @(negedge clk);
    chk("t4_clr", 32'(bus.mac_clr), 1);
    cyc();
    run_burst(3, 1, 8'd1, 8'd1);
    wait_resp(20, r_seen, r_id, r_data, r_err, r_lat);
    chk("t4b_id", 32'(r_id), 3);
    chk("t4b_data", 32'(r_data), 1);

    // Reset in the second RUN cycle of a 4-beat burst
    bus.req_valid[2] = 1'b1; bus.req_a[23:16] = 8'd4; bus.req_b[23:16] = 8'd4; bus.req_last[2] = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t5_run1_ready", 32'(bus.req_ready), 32'b0100);
    cyc();
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_rst");
    bus.req_valid[0] = 1'b1; bus.req_a[7:0] = 8'd6; bus.req_b[7:0] = 8'd7; bus.req_last[0] = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", 32'(bus.busy), 0);
    cyc();
    @(negedge clk);
    chk("t5_clr", 32'(bus.mac_clr), 1);
    cyc();
    @(negedge clk);
    chk("t5_ready", 32'(bus.req_ready), 32'b0001);
    cyc();
    bus.req_valid = '0; bus.req_last = '0;
    wait_resp(20, r_seen, r_id, r_data, r_err, r_lat);
    chk("t5_id", 32'(r_id), 0);
    chk("t5_data", 32'(r_data), 42);
    chk("t5_err", 32'(r_err), 0);

    // One beat 2*7 then a long stall
    bus.req_valid[1] = 1'b1; bus.req_a[15:8] = 8'd2; bus.req_b[15:8] = 8'd7; bus.req_last[1] = 1'b0;
    acc6 = 0;
    for (int c = 0; c < 10 && acc6 == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready[1]) acc6 = 1;
      cyc();
    end
    chk("t6_accepted", acc6, 1);
    bus.req_valid[1] = 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
    wait_resp(40, r_seen, r_id, r_data, r_err, r_lat);
    chk("t6_seen", 32'(r_seen), 1);
    chk("t6_err", 32'(r_err), 1);
    chk("t6_data", 32'(r_data), 14);
    chk("t6_id", 32'(r_id), 1);
    chk("t6_latency", r_lat, TIMEOUT + 1);
`else
    wait_resp(40, r_seen, r_id, r_data, r_err, r_lat);
    chk("t6_no_resp", 32'(r_seen), 0);
    @(negedge clk);
    chk("t6_still_busy", 32'(bus.busy), 1);
    chk("t6_still_ready", 32'(bus.req_ready), 32'b0010);
    cyc();
    run_burst(1, 1, 8'd0, 8'd0);
    wait_resp(20, r_seen, r_id, r_data, r_err, r_lat);
    chk("t6_late_data", 32'(r_data), 14);
    chk("t6_late_err", 32'(r_err), 0);
`endif

    // Randomized bursts against the round-robin / burst-sum model
    do_reset();
    m_ptr = 0; m_busy = 1'b0; exp_id = 0; served = 0; hold = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gen_burst(i);
      bub[i] = 0;
      pend[i] = 1'b0;
    end
    for (int c = 0; c < 4000 && served < NRESP; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic v;
        v = ($urandom_range(0, 3) != 0) || (bub[i] >= 2);
        bub[i] = v ? 0 : bub[i] + 1;
        bus.req_valid[i]    = v;
        bus.req_a[8*i +: 8] = ba[i][bidx[i]];
        bus.req_b[8*i +: 8] = bb[i][bidx[i]];
        bus.req_last[i]     = (bidx[i] == blen[i] - 1);
      end
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
      if (bus.req_ready != '0)
        chk("rnd_ready_owner", 32'(bus.req_ready), 32'(1) << exp_id);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          if (bidx[i] == blen[i] - 1) begin
            done_sum[i] = bsum[i];
            pend[i] = 1'b1;
            gen_burst(i);
          end else begin
            bidx[i]++;
          end
        end
      end
      nxt_busy = m_busy;
      if (hold) begin
        chk("rnd_hold_valid", 32'(bus.resp_valid), 1);
        chk("rnd_hold_id", 32'(bus.resp_id), 32'(hold_id));
        chk("rnd_hold_data", 32'(bus.resp_data), 32'(hold_data));
      end
      if (bus.resp_valid) begin
        if (bus.resp_ready) begin
          chk("rnd_resp_id", 32'(bus.resp_id), exp_id);
          chk("rnd_resp_data", 32'(bus.resp_data), done_sum[exp_id]);
          chk("rnd_resp_err", 32'(bus.resp_err), 0);
          chk("rnd_burst_done", 32'(pend[exp_id]), 1);
          pend[exp_id] = 1'b0;
          m_ptr = (exp_id + 1) % NREQ;
          served++;
          nxt_busy = 1'b0;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hold_id = bus.resp_id;
          hold_data = bus.resp_data;
        end
      end else begin
        hold = 1'b0;
      end
      if (!m_busy && bus.req_valid != '0) begin
        exp_id = rr_pick(m_ptr, bus.req_valid);
        nxt_busy = 1'b1;
      end
      m_busy = nxt_busy;
      cyc();
    end
    chk("rnd_served", served, NRESP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
